// File: rtl/glyph_blitter_pkg.sv
// Shared definitions for the glyph blitter: glyph codes, walker states and the 5x5 font bitmap.
// Each glyph is packed with row 0 (top) in the most significant five bits and MSB = leftmost column.
package glyph_blitter_pkg;

  localparam int FONT_W = 5;
  localparam int FONT_H = 5;

  localparam logic [4:0] GL_PLUS  = 5'd10;
  localparam logic [4:0] GL_MINUS = 5'd11;
  localparam logic [4:0] GL_MUL   = 5'd12;
  localparam logic [4:0] GL_DIV   = 5'd13;
  localparam logic [4:0] GL_EQ    = 5'd14;
  localparam logic [4:0] GL_BLANK = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [FONT_W*FONT_H-1:0] font_glyph(input logic [4:0] code);
    case (code)
      5'd0:     font_glyph = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
      5'd1:     font_glyph = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b01110};
      5'd2:     font_glyph = {5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111};
      5'd3:     font_glyph = {5'b11111, 5'b00001, 5'b01111, 5'b00001, 5'b11111};
      5'd4:     font_glyph = {5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001};
      5'd5:     font_glyph = {5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111};
      5'd6:     font_glyph = {5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111};
      5'd7:     font_glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b00100};
      5'd8:     font_glyph = {5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111};
      5'd9:     font_glyph = {5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111};
      GL_PLUS:  font_glyph = {5'b00100, 5'b00100, 5'b11111, 5'b00100, 5'b00100};
      GL_MINUS: font_glyph = {5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000};
      GL_MUL:   font_glyph = {5'b10101, 5'b01110, 5'b11111, 5'b01110, 5'b10101};
      GL_DIV:   font_glyph = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
      GL_EQ:    font_glyph = {5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000};
      default:  font_glyph = '0;
    endcase
  endfunction

  function automatic logic [FONT_W-1:0] font_row(input logic [4:0] code, input logic [7:0] row);
    logic [FONT_W*FONT_H-1:0] bitmap;
    bitmap   = font_glyph(code);
    font_row = '0;
    for (int r = 0; r < FONT_H; r++) begin
      if (row == 8'(r)) font_row = bitmap[(FONT_H-1-r)*FONT_W +: FONT_W];
    end
  endfunction

endpackage

// File: rtl/glyph_font_rom.sv
// Combinational font ROM: (glyph code, font row) -> one row of pixel bits, MSB = leftmost column.
// Rows at or beyond GLYPH_H read as zero.
module glyph_font_rom
  import glyph_blitter_pkg::*;
#(
  parameter int GLYPH_W = 5,
  parameter int GLYPH_H = 5,
  parameter int ROW_W   = 3
) (
  input  logic [4:0]         glyph_code,
  input  logic [ROW_W-1:0]   row,
  output logic [GLYPH_W-1:0] row_bits
);

  always_comb begin
    row_bits = '0;
    if (int'(row) < GLYPH_H) row_bits = GLYPH_W'(font_row(glyph_code, 8'(row)));
  end

endmodule

// File: rtl/glyph_blitter.sv
// Scaling glyph walker: latches a glyph code and scale on start, then streams the magnified
// glyph raster (x, y, on) left-to-right, top-to-bottom under a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | presenting pixels, advancing on each accepted pixel
// DONE  | one-cycle done pulse after the last pixel was accepted
module glyph_blitter
  import glyph_blitter_pkg::*;
#(
  parameter int GLYPH_W = 5,
  parameter int GLYPH_H = 5,
  parameter int SCALE_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         glyph_code,
  input  logic [SCALE_W-1:0] scale,
  output logic               busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [7:0]         pix_x,
  output logic [7:0]         pix_y,
  output logic               pix_on,
  output logic               done
);

  localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GLYPH_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GLYPH_H - 1);

  state_t             state_q, state_d;
  logic [4:0]         code_q;
  logic [SCALE_W-1:0] scale_q;
  logic [SCALE_W-1:0] sub_x_q, sub_y_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [7:0]         pix_x_q, pix_y_q;
  logic [GLYPH_W-1:0] row_bits;
  logic               accept, x_wrap, col_wrap, y_wrap, row_wrap, last_pix;

  assign accept   = (state_q == RUN) && pix_ready;
  assign x_wrap   = (sub_x_q == scale_q);
  assign col_wrap = x_wrap && (col_q == COL_LAST);
  assign y_wrap   = (sub_y_q == scale_q);
  assign row_wrap = y_wrap && (row_q == ROW_LAST);
  assign last_pix = col_wrap && row_wrap;

  glyph_font_rom #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .ROW_W   (ROW_W)
  ) u_font_rom (
    .glyph_code (code_q),
    .row        (row_q),
    .row_bits   (row_bits)
  );

  assign pix_x  = pix_x_q;
  assign pix_y  = pix_y_q;
  // Gated so the idle value is 0 rather than whatever glyph 0 holds at (0,0).
  assign pix_on = (state_q == RUN) && row_bits[COL_LAST - col_q];

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    pix_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        if (pix_ready && last_pix) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      scale_q <= '0;
      sub_x_q <= '0;
      sub_y_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        code_q  <= glyph_code;
        scale_q <= scale;
        sub_x_q <= '0;
        sub_y_q <= '0;
        col_q   <= '0;
        row_q   <= '0;
        pix_x_q <= '0;
        pix_y_q <= '0;
      end else if (accept) begin
        // pix_x/pix_y step by one per sub-pixel, so col*(s+1)+sub never needs a multiply.
        if (!x_wrap) begin
          sub_x_q <= sub_x_q + 1'b1;
          pix_x_q <= pix_x_q + 8'd1;
        end else if (!col_wrap) begin
          sub_x_q <= '0;
          col_q   <= col_q + 1'b1;
          pix_x_q <= pix_x_q + 8'd1;
        end else begin
          sub_x_q <= '0;
          col_q   <= '0;
          pix_x_q <= '0;
          if (!y_wrap) begin
            sub_y_q <= sub_y_q + 1'b1;
            pix_y_q <= pix_y_q + 8'd1;
          end else if (!row_wrap) begin
            sub_y_q <= '0;
            row_q   <= row_q + 1'b1;
            pix_y_q <= pix_y_q + 8'd1;
          end else begin
            sub_y_q <= '0;
            row_q   <= '0;
            pix_y_q <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/glyph_blitter.md
Name: glyph_blitter

Overview:
- Sequential successor to the per-glyph row ROMs in the VGA calculator display path.
- On a start request, latches a glyph code and an integer scale factor, then streams the scaled glyph as a raster of pixels (x, y, on/off) to the frame-buffer writer under a valid/ready handshake.
- Replaces one-ROM-per-symbol with a single parametrised font ROM plus a scaling walker.

Parameters:
- GLYPH_W, 5, glyph width in font pixels (bits per ROM row, MSB = leftmost column)
- GLYPH_H, 5, glyph height in font rows (row index 0 = top)
- SCALE_W, 2, width of scale input; magnification = scale+1, range 1..2^SCALE_W
- Constraint: GLYPH_W*2^SCALE_W <= 256 and GLYPH_H*2^SCALE_W <= 256

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request to draw; sampled only in IDLE
- glyph_code  in  5  symbol to draw; latched on accepted start
- scale  in  SCALE_W  magnification minus one; latched on accepted start
- busy  out  1  high in RUN and DONE
- pix_valid  out  1  current pixel is presented
- pix_ready  in  1  consumer accepts the pixel this cycle
- pix_x  out  8  scaled x coordinate within the glyph cell
- pix_y  out  8  scaled y coordinate within the glyph cell
- pix_on  out  1  pixel lit (font bit at current font column/row)
- done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset: state IDLE; busy, pix_valid and done = 0; pix_x, pix_y, pix_on = 0; all counters and latches cleared. Reset mid-RUN aborts immediately with no done pulse.
- States: IDLE -> RUN on start (the start-accept cycle); RUN -> DONE when the last pixel is accepted; DONE -> IDLE unconditionally after one cycle.
- start asserted in RUN or DONE is ignored and not queued.
- Latency: first pixel_valid in the cycle after start is sampled; pix_valid = 1 throughout RUN, 0 otherwise.
- Counters: col (0..GLYPH_W-1), sub_x (0..scale), row (0..GLYPH_H-1), sub_y (0..scale), plus pix_x and pix_y registers. No division is used.
- Advance only when pix_valid && pix_ready.
  - sub_x increments; on wrap, col increments.
  - On col wrap, sub_y increments; on sub_y wrap, row increments.
  - pix_x = col*(s+1)+sub_x, maintained incrementally and reset to 0 at each line. pix_y is maintained likewise.
- Raster order is left-to-right, top-to-bottom.
- Handshake: while pix_ready = 0, pix_x, pix_y and pix_on hold stable. The total pixel count is GLYPH_W*GLYPH_H*(s+1)^2 regardless of stalls.
- Last pixel: pix_x = GLYPH_W*(s+1)-1 and pix_y = GLYPH_H*(s+1)-1, accepted. done = 1 in DONE only.
- pix_on is combinational from the font ROM, addressed by the latched code, row and col. It has no added latency relative to pix_x and pix_y.
- Font codes:
  - 0-9 digits; 10 '+'; 11 '-'; 12 '*'; 13 '/'; 14 '='; 15-31 blank (all rows 0).
  - '-' = row 2 11111, all other rows 0.
  - '+' = 00100, 00100, 11111, 00100, 00100.
  - '=' = 00000, 11111, 00000, 11111, 00000.
  - '0' = 11111, 10001, 10001, 10001, 11111.
- Rows >= GLYPH_H read 0. This is unreachable in normal operation.

Decomposition:
- Shared include file: glyph code constants (GL_PLUS=10, GL_MINUS=11, GL_MUL=12, GL_DIV=13, GL_EQ=14, GL_BLANK=15), state encodings (IDLE, RUN, DONE), and the font bitmap table.
- One sub-module, glyph_font_rom: combinational (glyph_code, row) -> GLYPH_W-bit row pattern, with a zero default.
- The walker FSM and counters live in glyph_blitter.

Test Plan:
- Minus, scale=0, pix_ready=1: start -> pix_valid next cycle; 25 pixels; pix_on = 1 exactly for y=2, x=0..4; done pulses once, 26 cycles after start; busy drops the following cycle.
- Minus, scale=1: 100 pixels (10x10); pix_on = 1 only for y in {4,5}, all x; last pixel (9,9); single done pulse.
- Plus, scale=0, pix_ready toggling 1,0,1,0: coordinates and pix_on hold during stalls; exactly 25 acceptances; pix_on pattern matches '+' bitmap; done only after the 25th acceptance.
- start pulsed mid-RUN with glyph_code=14: ignored; the original glyph completes unchanged; no second run starts.
- reset asserted at pixel 7 of '0' at scale=2: next cycle busy=0, pix_valid=0, done never pulses; a fresh start draws from (0,0).
- glyph_code=20, scale=3: 400 pixels, all pix_on=0, last pixel (19,19), done pulses.
